strobe_slot_scheduler: RTL



---
 rtl/strobe_sched_pkg.sv | 41 ++++
 rtl/strobe_slot_scheduler_tick.sv | 50 +++++
 rtl/strobe_slot_scheduler.sv | 130 +++++++++++++
 3 files changed

// File: rtl/strobe_sched_pkg.sv
// Shared types and the round-robin helper for the strobe slot scheduler.
package strobe_sched_pkg;

    // Upper bound on requesters the round-robin helper can search.
    localparam int RR_MAX_REQ = 32;
    localparam int RR_IDX_W   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2
    } sched_state_e;

    // First requester with req set, searching upward from last_id+1 modulo n_req.
    // Returns 0 when nothing is requesting; callers only use it with req != 0.
    function automatic int rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                   input int                    last_id,
                                   input int                    n_req);
        int                  win;
        logic                found;
        logic [RR_IDX_W-1:0] idx;
        win   = 0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= RR_MAX_REQ; i++) begin
            if (!found && (i <= n_req)) begin
                idx = RR_IDX_W'((last_id + i) % n_req);
                if (req[idx]) begin
                    win   = int'(idx);
                    found = 1'b1;
                end else begin
                    found = 1'b0;
                end
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/strobe_slot_scheduler_tick.sv
// Period counter: one registered strobe cycle every STROBE_PERIOD enabled cycles.
module strobe_tick
    import strobe_sched_pkg::*;
#(
    parameter int STROBE_PERIOD = 3
) (
    input  logic clk,
    input  logic rst_l,
    input  logic en,
    output logic strobe
);

    localparam int             CNT_W    = (STROBE_PERIOD > 1) ? $clog2(STROBE_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             strobe_q;
    logic             strobe_d;

    // Next count and strobe: en low clears, wrap raises the strobe for one cycle.
    always_comb begin
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
        if (!en) begin
            cnt_d    = '0;
            strobe_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            strobe_d = 1'b1;
        end else begin
            cnt_d    = cnt_q + CNT_W'(1);
            strobe_d = 1'b0;
        end
    end

    // Counter and strobe registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe = strobe_q;

endmodule

// File: rtl/strobe_slot_scheduler.sv
// Round-robin slot scheduler sharing a periodic strobe between N_REQ requesters.
module strobe_slot_scheduler
    import strobe_sched_pkg::*;
#(
    parameter  int STROBE_PERIOD = 3,
    parameter  int N_REQ         = 4,
    parameter  int MAX_HOLD      = 8,
    localparam int ID_W          = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1,
    localparam int HOLD_W        = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic             strobe_out,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             busy,
    output logic             timeout
);

    localparam logic [N_REQ-1:0]  GRANT_ONE = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [ID_W-1:0]   ID_LAST   = ID_W'(N_REQ - 1);

    sched_state_e      state_q,    state_d;
    logic [N_REQ-1:0]  grant_q,    grant_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [ID_W-1:0]   last_id_q,  last_id_d;
    logic [HOLD_W-1:0] hold_q,     hold_d;
    logic              busy_q,     busy_d;
    logic              timeout_q,  timeout_d;
    logic [ID_W-1:0]   pick_id_s;
    logic              done_hit_s;
    logic              tick_s;

    strobe_tick #(
        .STROBE_PERIOD (STROBE_PERIOD)
    ) u_tick (
        .clk    (clk),
        .rst_l  (rst_l),
        .en     (en),
        .strobe (tick_s)
    );

    // Arbitration and grant lifetime: pick on an unused tick, hold until done or timeout.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        last_id_d  = last_id_q;
        hold_d     = hold_q;
        timeout_d  = 1'b0;
        pick_id_s  = ID_W'(rr_pick(RR_MAX_REQ'(req), int'(last_id_q), N_REQ));
        done_hit_s = done[grant_id_q];
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (tick_s && (req != '0)) begin
                    grant_d    = GRANT_ONE << pick_id_s;
                    grant_id_d = pick_id_s;
                    last_id_d  = pick_id_s;
                    hold_d     = '0;
                    state_d    = GRANT;
                end else begin
                    state_d = WAIT;
                end
            end
            GRANT: begin
                hold_d = hold_q + HOLD_W'(1);
                // done takes priority over a timeout landing on the same cycle
                if (done_hit_s) begin
                    grant_d = '0;
                    hold_d  = '0;
                    state_d = en ? WAIT : IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    grant_d   = '0;
                    hold_d    = '0;
                    timeout_d = 1'b1;
                    state_d   = en ? WAIT : IDLE;
                end else begin
                    state_d = GRANT;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                hold_d  = '0;
            end
        endcase
        busy_d = (grant_d != '0);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            last_id_q  <= ID_LAST;
            hold_q     <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign strobe_out = tick_s;
    assign grant      = grant_q;
    assign grant_id   = grant_id_q;
    assign busy       = busy_q;
    assign timeout    = timeout_q;

endmodule
